hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It consumes the EX-side outputs of the ID/EX pipeline register together with the register-source fields of the instruction currently in ID. It generates the hold, bubble and flush controls that drive the PC, IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards, stretches them over a configurable stall length with a small state machine, handles taken-branch flushes and data-memory wait, and keeps stall/flush event counters.

## Interface
Parameters:
- REG_AW, 5, register-address width (matches `XREG_ADDRWIDTH`)
- STALL_CYCLES, 1, load-use stall length in cycles; legal range 1..15
- CNT_W, 32, width of the event counters
- LOAD_OPCODE, 7'b0000011, opcode identifying loads in EX

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1_addr  in  REG_AW  rs1 of the instruction in ID
- id_rs1_used  in  1  the ID instruction reads rs1
- id_rs2_addr  in  REG_AW  rs2 of the instruction in ID
- id_rs2_used  in  1  the ID instruction reads rs2
- ex_opcode  in  7  opcode currently in EX (ID/EX output)
- ex_rd_en  in  1  the EX instruction writes rd
- ex_rd_addr  in  REG_AW  rd of the EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- mem_busy  in  1  data memory not ready; whole pipe must freeze
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF/ID keeps its contents
- id_ex_hold  out  1  ID/EX keeps its contents
- id_ex_bubble  out  1  ID/EX loads a NOP (all fields zero, rd_en=0)
- ex_mem_hold  out  1  EX/MEM keeps its contents
- if_id_flush  out  1  IF/ID loads a NOP
- stall_cnt  out  CNT_W  cycles with a load-use stall
- flush_cnt  out  CNT_W  branch-flush events

## Operation
- load_use = id_valid & (ex_opcode==LOAD_OPCODE) & ex_rd_en & (ex_rd_addr!=0) & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
- States: RUN, LOAD_STALL. There is a 4-bit down-counter `remain`.
- Priority in every state: mem_busy > ex_branch_taken > load-use/LOAD_STALL.
- mem_busy=1:
  - pc_hold, if_id_hold, id_ex_hold and ex_mem_hold are 1. All other outputs are 0.
  - state, remain and counters are frozen.
- ex_branch_taken=1, mem_busy=0:
  - if_id_flush=1 and id_ex_bubble=1. Hold outputs are 0.
  - flush_cnt+1. Next state is RUN, remain=0. This cancels any LOAD_STALL in progress.
- RUN with load_use and no higher-priority event:
  - pc_hold=1, if_id_hold=1, id_ex_bubble=1, stall_cnt+1.
  - If STALL_CYCLES>1: go to LOAD_STALL with remain=STALL_CYCLES-1. Otherwise stay in RUN.
- LOAD_STALL with no higher-priority event:
  - Same outputs as the load-use case. stall_cnt+1, remain-1.
  - When remain==1, return to RUN. load_use is not re-evaluated while in LOAD_STALL.
- RUN with no event: all control outputs 0.
- Counters wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from the current state and inputs, and are valid in the same cycle as the hazard. State and counters are registered.
- While rst=0, all outputs are forced to 0. Reset values: state=RUN, remain=0, stall_cnt=0, flush_cnt=0.
- Reset assertion mid-stall aborts the stall immediately. After release the unit starts in RUN.
- A load-use stall lasts exactly STALL_CYCLES non-frozen cycles. Cycles frozen by mem_busy do not count toward it.
- A branch flush lasts 1 cycle. Back-to-back taken branches flush on every such cycle.
- A load in EX with rd=x0, rd_en=0, or a consumer with id_valid=0 never stalls.

## Test plan
- Load x5 in EX, ID reads rs2=x5 with rs2_used=1, STALL_CYCLES=1 -> one cycle of pc_hold=if_id_hold=id_ex_bubble=1, then all 0. stall_cnt goes 0->1.
- STALL_CYCLES=3, load-use on rs1, ex_opcode driven NOP after the first cycle -> holds and bubble stay high for exactly 3 cycles. stall_cnt=3, state back to RUN.
- Load-use and ex_branch_taken in the same cycle -> if_id_flush=id_ex_bubble=1, pc_hold=0. flush_cnt=1, stall_cnt=0.
- STALL_CYCLES=3, mem_busy high for 2 cycles during the second stall cycle -> all four holds=1 for those 2 cycles. The stall then finishes its remaining 2 cycles: total 5 cycles of pc_hold, stall_cnt=3.
- Load to x0, ID reads x0; also a load with rd_en=0 -> no stall, counters unchanged.
- rst pulsed low during the 2nd cycle of a 3-cycle stall -> outputs drop to 0 asynchronously, counters read 0. The first cycle after release shows no hold unless load_use is true.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and memory-wait control for the 5-stage RV32 pipe
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W = 32,
  parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs2_used,
  input  logic [6:0]        ex_opcode,
  input  logic              ex_rd_en,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              id_ex_hold,
  output logic              id_ex_bubble,
  output logic              ex_mem_hold,
  output logic              if_id_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef enum logic {RUN, LOAD_STALL} state_t;
  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] remain_q, remain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic rs1_hit, rs2_hit, load_use, flush_now, stall_now;
  assign rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  assign load_use = id_valid && (ex_opcode == LOAD_OPCODE) && ex_rd_en
                 && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);
  assign flush_now = !mem_busy && ex_branch_taken;
  // an active stall ignores load_use so its length stays fixed
  assign stall_now = !mem_busy && !ex_branch_taken && (state_q == LOAD_STALL || load_use);
  always_comb begin
    state_d = state_q;
    remain_d = remain_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_now) begin
      state_d = RUN;
      remain_d = '0;
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (stall_now) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (state_q == LOAD_STALL) begin
        remain_d = remain_q - 4'd1;
        state_d = (remain_q == 4'd1) ? RUN : LOAD_STALL;
      end else if (STALL_CYCLES > 1) begin
        state_d = LOAD_STALL;
        remain_d = STALL_INIT;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      remain_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      remain_q <= remain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign pc_hold = rst && (mem_busy || stall_now);
  assign if_id_hold = rst && (mem_busy || stall_now);
  assign id_ex_hold = rst && mem_busy;
  assign ex_mem_hold = rst && mem_busy;
  assign id_ex_bubble = rst && (flush_now || stall_now);
  assign if_id_flush = rst && flush_now;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench driving a 1-cycle and a 3-cycle stall instance with shared stimulus
module tb_hazard_ctrl;
  logic clk = 0, rst = 0;
  logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, ex_rd_en = 0, br = 0, mem_busy = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic [6:0] op = 0;
  logic pc_a, ifh_a, idh_a, bub_a, exh_a, fl_a, pc_b, ifh_b, idh_b, bub_b, exh_b, fl_b;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
  typedef struct {
    logic [5:0] ctl_a, ctl_b;
    logic [31:0] sa, fa, sb, fb;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int left_a = 0, left_b = 0;
  logic [31:0] ms_a = 0, mf_a = 0, ms_b = 0, mf_b = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(rs1), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(rs2), .id_rs2_used(id_rs2_used), .ex_opcode(op), .ex_rd_en(ex_rd_en),
    .ex_rd_addr(rd), .ex_branch_taken(br), .mem_busy(mem_busy), .pc_hold(pc_a),
    .if_id_hold(ifh_a), .id_ex_hold(idh_a), .id_ex_bubble(bub_a), .ex_mem_hold(exh_a),
    .if_id_flush(fl_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

  hazard_ctrl #(.STALL_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(rs1), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(rs2), .id_rs2_used(id_rs2_used), .ex_opcode(op), .ex_rd_en(ex_rd_en),
    .ex_rd_addr(rd), .ex_branch_taken(br), .mem_busy(mem_busy), .pc_hold(pc_b),
    .if_id_hold(ifh_b), .id_ex_hold(idh_b), .id_ex_bubble(bub_b), .ex_mem_hold(exh_b),
    .if_id_flush(fl_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

  // control vector order: pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, ex_mem_hold, if_id_flush
  task automatic model(input int cycles, inout int left, inout logic [31:0] scnt,
                       inout logic [31:0] fcnt, output logic [5:0] ctl,
                       output logic [31:0] s_now, output logic [31:0] f_now);
    logic lu;
    lu = id_valid && op == 7'b0000011 && ex_rd_en && rd != 0
      && ((id_rs1_used && rs1 == rd) || (id_rs2_used && rs2 == rd));
    ctl = 6'b000000;
    if (!rst) begin
      left = 0; scnt = 0; fcnt = 0; s_now = 0; f_now = 0;
      return;
    end
    s_now = scnt;
    f_now = fcnt;
    if (mem_busy) ctl = 6'b111010;
    else if (br) begin
      ctl = 6'b000101; left = 0; fcnt = fcnt + 1;
    end else if (left > 0 || lu) begin
      ctl = 6'b110100; scnt = scnt + 1;
      left = (left > 0) ? left - 1 : cycles - 1;
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2, input logic [6:0] o,
                       input logic re, input logic [4:0] d, input logic b, input logic m);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; rs1 = a1; id_rs1_used = u1; rs2 = a2; id_rs2_used = u2;
    op = o; ex_rd_en = re; rd = d; br = b; mem_busy = m;
    model(1, left_a, ms_a, mf_a, e.ctl_a, e.sa, e.fa);
    model(3, left_b, ms_b, mf_b, e.ctl_b, e.sb, e.fb);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 5'd1, 1, 5'd2, 1, 7'h13, 1, 5'd9, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctl_a", {26'd0, pc_a, ifh_a, idh_a, bub_a, exh_a, fl_a}, {26'd0, e.ctl_a});
      chk("ctl_b", {26'd0, pc_b, ifh_b, idh_b, bub_b, exh_b, fl_b}, {26'd0, e.ctl_b});
      chk("stall_cnt_a", sc_a, e.sa);
      chk("flush_cnt_a", fc_a, e.fa);
      chk("stall_cnt_b", sc_b, e.sb);
      chk("flush_cnt_b", fc_b, e.fb);
    end
  end

  localparam logic [6:0] LD = 7'b0000011, NOP = 7'h13;

  initial begin
    // reset held with a live hazard on the inputs
    drive(0, 1, 5'd5, 1, 5'd0, 0, LD, 1, 5'd5, 0, 0);
    drive(0, 1, 5'd5, 1, 5'd0, 0, LD, 1, 5'd5, 0, 0);
    idle(2);
    // load x5, consumer reads rs2
    drive(1, 1, 5'd0, 0, 5'd5, 1, LD, 1, 5'd5, 0, 0);
    idle(4);
    // load-use on rs1, EX turns NOP afterwards
    drive(1, 1, 5'd7, 1, 5'd0, 0, LD, 1, 5'd7, 0, 0);
    idle(4);
    // load-use together with a taken branch
    drive(1, 1, 5'd7, 1, 5'd0, 0, LD, 1, 5'd7, 1, 0);
    idle(2);
    // mem_busy in the second stall cycle
    drive(1, 1, 5'd3, 1, 5'd0, 0, LD, 1, 5'd3, 0, 0);
    drive(1, 1, 5'd1, 1, 5'd2, 1, NOP, 1, 5'd9, 0, 1);
    drive(1, 1, 5'd1, 1, 5'd2, 1, NOP, 1, 5'd9, 0, 1);
    idle(4);
    // back-to-back branches, then non-hazard loads
    drive(1, 1, 5'd1, 1, 5'd2, 1, NOP, 1, 5'd9, 1, 0);
    drive(1, 1, 5'd1, 1, 5'd2, 1, NOP, 1, 5'd9, 1, 0);
    drive(1, 1, 5'd0, 1, 5'd0, 1, LD, 1, 5'd0, 0, 0);
    drive(1, 1, 5'd6, 1, 5'd6, 1, LD, 0, 5'd6, 0, 0);
    drive(1, 0, 5'd6, 1, 5'd6, 1, LD, 1, 5'd6, 0, 0);
    drive(1, 1, 5'd6, 0, 5'd6, 0, LD, 1, 5'd6, 0, 0);
    idle(1);
    // reset during the second stall cycle
    drive(1, 1, 5'd4, 1, 5'd0, 0, LD, 1, 5'd4, 0, 0);
    drive(0, 1, 5'd1, 1, 5'd2, 1, NOP, 1, 5'd9, 0, 0);
    idle(3);
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 3));
      drive($urandom_range(0, 99) >= 2, $urandom_range(0, 9) != 0,
            5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            ($urandom_range(0, 1) != 0) ? LD : NOP, $urandom_range(0, 7) != 0, d,
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
